// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM states
// and the nibble-count helper.
package nibble_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of nibbles in a WIDTH-bit operand
  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit adder slice.
// Ports: a, b   - operand nibbles
//        cin    - carry in
//        s      - nibble sum
//        cout   - carry out of bit 3
//        c3     - carry into bit 3 (used for signed overflow)
module nibble_add
  import nibble_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout,
  output logic             c3
);

  logic [NIB_W-1:0] low;
  logic [NIB_W:0]   full;

  // Lower three bits alone; their carry-out is the carry into the top bit
  assign low  = {1'b0, a[NIB_W-2:0]} + {1'b0, b[NIB_W-2:0]} + NIB_W'(cin);
  assign full = {1'b0, a} + {1'b0, b} + (NIB_W+1)'(cin);

  assign s    = full[NIB_W-1:0];
  assign cout = full[NIB_W];
  assign c3   = low[NIB_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock, LSB nibble first, with
// a registered carry between nibbles. Valid/ready handshake on both sides.
// Optional macro OVERFLOW_FLAG_EN adds the OVF (signed overflow) output.
// Ports: CLK, RST (async, active-high)
//        IN_VALID/IN_READY, A, B, CIN      - operand handshake
//        OUT_VALID/OUT_READY, SUM, COUT    - result handshake
//        BUSY                              - high in RUN or DONE
//        OVF                               - signed overflow (macro only)
module nibble_serial_adder
  import nibble_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             BUSY
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned NIBBLES = nib_count(WIDTH);
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry, cout_r, out_valid_r, busy_r, ovf_r;
  logic [NIB_W-1:0] a_nib, b_nib, s_nib;
  logic             nib_cout, nib_c3;
  logic             accept, last;

  assign IN_READY = (state == IDLE) & ~RST;
  assign accept   = IN_VALID & IN_READY;
  assign last     = (state == RUN) && (idx == LAST);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (OUT_READY) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Select the current operand nibbles
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_r[i*NIB_W +: NIB_W];
        b_nib = b_r[i*NIB_W +: NIB_W];
      end
    end
  end

  nibble_add u_nibble_add (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .s    (s_nib),
    .cout (nib_cout),
    .c3   (nib_c3)
  );

  // Operand capture, nibble-serial accumulation and result flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (accept) begin
        a_r   <= A;
        b_r   <= B;
        carry <= CIN;
        idx   <= '0;
      end else if (state == RUN) begin
        for (int i = 0; i < int'(NIBBLES); i++) begin
          if (idx == IDX_W'(i)) sum_r[i*NIB_W +: NIB_W] <= s_nib;
        end
        carry <= nib_cout;
        idx   <= idx + IDX_W'(1);
        if (last) begin
          cout_r <= nib_cout;
          ovf_r  <= nib_c3 ^ nib_cout;
        end
      end
      out_valid_r <= (state_nxt == DONE);
      busy_r      <= (state_nxt != IDLE);
    end
  end

  assign SUM       = sum_r;
  assign COUT      = cout_r;
  assign OUT_VALID = out_valid_r;
  assign BUSY      = busy_r;
`ifdef OVERFLOW_FLAG_EN
  assign OVF       = ovf_r;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_r ^ nib_c3;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: 16-bit and 4-bit instances,
// randomized operands checked against a plain-arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int unsigned W = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID16, IN_READY16, CIN16, OUT_VALID16, OUT_READY16, COUT16, BUSY16;
  logic [15:0] A16, B16, SUM16;
  logic        IN_VALID4, IN_READY4, CIN4, OUT_VALID4, OUT_READY4, COUT4, BUSY4;
  logic [3:0]  A4, B4, SUM4;
`ifdef OVERFLOW_FLAG_EN
  logic        OVF16, OVF4;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit rnd_rdy = 1'b0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];

  always #5 CLK = ~CLK;
  initial forever begin @(posedge CLK); cyc++; end

  nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID16), .IN_READY(IN_READY16),
    .A(A16), .B(B16), .CIN(CIN16), .OUT_VALID(OUT_VALID16), .OUT_READY(OUT_READY16),
    .SUM(SUM16), .COUT(COUT16), .BUSY(BUSY16)
`ifdef OVERFLOW_FLAG_EN
    , .OVF(OVF16)
`endif
  );

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID4), .IN_READY(IN_READY4),
    .A(A4), .B(B4), .CIN(CIN4), .OUT_VALID(OUT_VALID4), .OUT_READY(OUT_READY4),
    .SUM(SUM4), .COUT(COUT4), .BUSY(BUSY4)
`ifdef OVERFLOW_FLAG_EN
    , .OVF(OVF4)
`endif
  );

  // Reference: unsigned add modulo 2^w, carry out, signed overflow
  function automatic exp_t model(input int unsigned w, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin, input int acc);
    exp_t        m;
    logic [16:0] t;
    logic [15:0] mask;
    mask   = 16'((32'd1 << w) - 32'd1);
    t      = 17'(a & mask) + 17'(b & mask) + 17'(cin);
    m.sum  = t[15:0] & mask;
    m.cout = t[w];
    m.ovf  = (a[w-1] == b[w-1]) && (m.sum[w-1] != a[w-1]);
    m.acc  = acc;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor for the 16-bit instance
  initial begin
    exp_t e;
    bit   pv = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) pv = 1'b0;
      else begin
        if (OUT_VALID16) begin
          chk("in_ready16_done", 32'(IN_READY16), 32'd0);
          chk("busy16_done", 32'(BUSY16), 32'd1);
          if (q16.size() == 0) chk("unexpected_out16", 32'd1, 32'd0);
          else begin
            e = q16[0];
            if (!pv) chk("latency16", 32'(cyc - e.acc), 32'(W / 4));
            chk("sum16", 32'(SUM16), 32'(e.sum));
            chk("cout16", 32'(COUT16), 32'(e.cout));
`ifdef OVERFLOW_FLAG_EN
            chk("ovf16", 32'(OVF16), 32'(e.ovf));
`endif
            if (OUT_READY16) void'(q16.pop_front());
          end
        end
        pv = OUT_VALID16 && !OUT_READY16;
      end
    end
  end

  // Monitor for the 4-bit instance
  initial begin
    exp_t e;
    bit   pv = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) pv = 1'b0;
      else begin
        if (OUT_VALID4) begin
          if (q4.size() == 0) chk("unexpected_out4", 32'd1, 32'd0);
          else begin
            e = q4[0];
            if (!pv) chk("latency4", 32'(cyc - e.acc), 32'd1);
            chk("sum4", 32'(SUM4), 32'(e.sum));
            chk("cout4", 32'(COUT4), 32'(e.cout));
`ifdef OVERFLOW_FLAG_EN
            chk("ovf4", 32'(OVF4), 32'(e.ovf));
`endif
            if (OUT_READY4) void'(q4.pop_front());
          end
        end
        pv = OUT_VALID4 && !OUT_READY4;
      end
    end
  end

  // Random consumer backpressure on the 16-bit instance when enabled
  initial forever begin
    @(posedge CLK); #1;
    if (rnd_rdy) OUT_READY16 = ($urandom_range(0, 3) != 0);
  end

  // Called one time unit after a rising edge; returns likewise
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int n = 0;
    IN_VALID16 = 1'b1; A16 = a; B16 = b; CIN16 = cin;
    @(negedge CLK);
    while (!IN_READY16 && n < 100) begin @(negedge CLK); n++; end
    if (!IN_READY16) chk("accept16_timeout", 32'd0, 32'd1);
    else q16.push_back(model(16, a, b, cin, cyc + 1));
    @(posedge CLK); #1;
    IN_VALID16 = 1'b0; A16 = 16'($urandom); B16 = 16'($urandom); CIN16 = 1'($urandom);
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int n = 0;
    IN_VALID4 = 1'b1; A4 = a; B4 = b; CIN4 = cin;
    @(negedge CLK);
    while (!IN_READY4 && n < 100) begin @(negedge CLK); n++; end
    if (!IN_READY4) chk("accept4_timeout", 32'd0, 32'd1);
    else q4.push_back(model(4, {12'd0, a}, {12'd0, b}, cin, cyc + 1));
    @(posedge CLK); #1;
    IN_VALID4 = 1'b0; A4 = 4'($urandom); B4 = 4'($urandom); CIN4 = 1'($urandom);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((q16.size() != 0 || q4.size() != 0) && n < 400) begin @(posedge CLK); n++; end
    #1;
    if (q16.size() != 0 || q4.size() != 0) chk({nm, "_drain_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b1;
    IN_VALID16 = 1'b0; A16 = '0; B16 = '0; CIN16 = 1'b0; OUT_READY16 = 1'b1;
    IN_VALID4  = 1'b0; A4  = '0; B4  = '0; CIN4  = 1'b0; OUT_READY4  = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_sum", 32'(SUM16), 32'd0);
    chk("rst_cout", 32'(COUT16), 32'd0);
    chk("rst_out_valid", 32'(OUT_VALID16), 32'd0);
    chk("rst_busy", 32'(BUSY16), 32'd0);
    chk("rst_in_ready", 32'(IN_READY16), 32'd0);
    RST = 1'b0;
    #1 chk("idle_in_ready", 32'(IN_READY16), 32'd1);
    @(posedge CLK); #1;

    // Basic add, carry through all nibbles, all-ones with carry-in
    send16(16'h0001, 16'h0002, 1'b0);
    drain("basic");
    send16(16'hFFFF, 16'h0001, 1'b0);
    send16(16'hFFFF, 16'hFFFF, 1'b1);
    send16(16'h7FFF, 16'h0001, 1'b0);
    send16(16'h8000, 16'h8000, 1'b0);
    drain("directed");

    // Randomized operands with random consumer stalls
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) send16(16'($urandom), 16'($urandom), 1'($urandom));
    rnd_rdy = 1'b0;
    @(posedge CLK); #1;
    OUT_READY16 = 1'b1;
    drain("random");

    // Backpressure in DONE while new operands are offered
    OUT_READY16 = 1'b0;
    send16(16'h00FF, 16'h0F01, 1'b1);
    n = 0;
    while (!OUT_VALID16 && n < 50) begin @(posedge CLK); #1; n++; end
    chk("bp_reached_done", 32'(OUT_VALID16), 32'd1);
    for (int i = 0; i < 5; i++) begin
      IN_VALID16 = 1'(i % 2 == 0); A16 = 16'($urandom); B16 = 16'($urandom);
      @(posedge CLK); #1;
    end
    IN_VALID16 = 1'b0;
    OUT_READY16 = 1'b1;
    @(posedge CLK); #1;
    chk("bp_release_valid", 32'(OUT_VALID16), 32'd0);
    chk("bp_release_in_ready", 32'(IN_READY16), 32'd1);
    chk("bp_release_busy", 32'(BUSY16), 32'd0);
    drain("bp");

    // Reset during the second RUN cycle
    send16(16'h1111, 16'h2222, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("midrst_sum", 32'(SUM16), 32'd0);
    chk("midrst_cout", 32'(COUT16), 32'd0);
    chk("midrst_out_valid", 32'(OUT_VALID16), 32'd0);
    chk("midrst_busy", 32'(BUSY16), 32'd0);
    chk("midrst_in_ready", 32'(IN_READY16), 32'd0);
    q16.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    send16(16'h1234, 16'h4321, 1'b1);
    drain("after_rst");

    // Single-nibble instance
    send4(4'hF, 4'h1, 1'b0);
    drain("w4_directed");
    for (int i = 0; i < 12; i++) send4(4'($urandom), 4'($urandom), 1'($urandom));
    drain("w4_random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
